nibble_serial_tx: RTL



---
 rtl/nibble_serial_tx_pkg.sv | 25 ++
 rtl/nibble_serial_tx_bit_timer.sv | 32 +++
 rtl/nibble_serial_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/nibble_serial_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter.
// Holds the FSM state enum, line levels and the frame length helper.
package nibble_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int frame_len(
        input int data_w,
        input int clks_per_bit,
        input int parity_en
    );
        return (2 + data_w + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Per-bit cycle counter for the serial transmitter.
// Pulses bit_end on the last clock of every line bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign bit_end = run && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_q <= '0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/nibble_serial_tx.sv
// Framed serial transmitter: start, data LSB first, even parity, stop.
// Line output is registered so it never follows the inputs combinationally.
module nibble_serial_tx
    import nibble_serial_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_vector,
    output logic              out_serial,
    output logic              out_busy,
    output logic              out_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_nxt;
    logic [BW-1:0]     bit_q, bit_d;
    logic              par_q, par_d;
    logic              line_q, line_d;
    logic              accept;
    logic              bit_end;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign out_busy   = (state_q != IDLE);
    assign out_done   = (state_q == STOP) && bit_end && !rst;
    assign out_serial = line_q;
    assign shift_nxt  = shift_q >> 1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(accept),
        .run    (out_busy),
        .bit_end(bit_end)
    );

    // line_d is the level the line takes in the state being entered
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                line_d = LINE_IDLE;
                if (accept) begin
                    state_d = START;
                    shift_d = in_vector;
                    par_d   = ^in_vector;
                    bit_d   = '0;
                    line_d  = START_BIT;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    line_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            line_d  = par_q;
                        end else begin
                            state_d = STOP;
                            line_d  = STOP_BIT;
                        end
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_nxt;
                        line_d  = shift_nxt[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    line_d  = STOP_BIT;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    line_d  = LINE_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            line_q  <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

endmodule
